// File: rtl/soc_selftest.sv
// Self-test sequencer: pulses SoC reset, runs the core, then reads back and checks registers.
// Optional SOC_SELFTEST_HALT_EN: cpu_halt ends RUN early; run_cycles expiry becomes a timeout.
module soc_selftest #(
  parameter int NUM_CHECKS   = 4,
  parameter int XLEN         = 32,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_W        = 16,
  localparam int IDX_W = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [4:0]       cfg_reg,
  input  logic [XLEN-1:0]  cfg_exp,
  input  logic             cfg_en,
  input  logic [RUN_W-1:0] run_cycles,
  input  logic             start,
`ifdef SOC_SELFTEST_HALT_EN
  input  logic             cpu_halt,
  output logic             timeout,
`endif
  output logic             cpu_reset_n,
  output logic [4:0]       dbg_addr,
  input  logic [XLEN-1:0]  dbg_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [IDX_W-1:0] fail_idx,
  output logic [XLEN-1:0]  fail_value
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST  = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_ADDR = 3'd3;
  localparam logic [2:0] S_CMP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [RC_W-1:0]  RST_LAST = RC_W'(RESET_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST     = IDX_W'(NUM_CHECKS - 1);

  logic [2:0]       state;
  logic [RC_W-1:0]  rst_cnt;
  logic [RUN_W-1:0] run_cnt;
  logic [RUN_W-1:0] run_lat;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] nxt_idx;
  logic             run_expire;
  logic             cfg_ok;

  logic [4:0]            slot_reg [NUM_CHECKS];
  logic [XLEN-1:0]       slot_exp [NUM_CHECKS];
  logic [NUM_CHECKS-1:0] slot_en;

  always_comb begin
    nxt_idx    = idx + IDX_W'(1);
    run_expire = (run_lat == '0) || (run_cnt == run_lat - RUN_W'(1));
    cfg_ok     = cfg_we && !busy && (int'(cfg_idx) < NUM_CHECKS);
  end

  // Slot contents carry no reset; validity is held in slot_en.
  always_ff @(posedge clk) begin
    if (cfg_ok) begin
      slot_reg[cfg_idx] <= cfg_reg;
      slot_exp[cfg_idx] <= cfg_exp;
    end
  end

  // dbg_addr is loaded one cycle ahead of ADDR so the read data lands in CMP;
  // it only ever changes to an enabled slot's register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cpu_reset_n <= 1'b1;
      dbg_addr    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_idx    <= '0;
      fail_value  <= '0;
      slot_en     <= '0;
`ifdef SOC_SELFTEST_HALT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      if (cfg_ok) slot_en[cfg_idx] <= cfg_en;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state       <= S_RST;
            busy        <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_idx    <= '0;
            fail_value  <= '0;
            cpu_reset_n <= 1'b0;
            rst_cnt     <= '0;
            run_cnt     <= '0;
            run_lat     <= run_cycles;
            idx         <= '0;
`ifdef SOC_SELFTEST_HALT_EN
            timeout     <= 1'b0;
`endif
          end
        end
        S_RST: begin
          if (rst_cnt == RST_LAST) begin
            state       <= S_RUN;
            cpu_reset_n <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_RUN: begin
`ifdef SOC_SELFTEST_HALT_EN
          if (cpu_halt) begin
            state <= S_ADDR;
            if (slot_en[0]) dbg_addr <= slot_reg[0];
          end else if (run_expire) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            timeout    <= 1'b1;
            fail_idx   <= '0;
            fail_value <= '0;
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
`else
          if (run_expire) begin
            state <= S_ADDR;
            if (slot_en[0]) dbg_addr <= slot_reg[0];
          end else begin
            run_cnt <= run_cnt + RUN_W'(1);
          end
`endif
        end
        S_ADDR: begin
          if (slot_en[idx]) begin
            state <= S_CMP;
          end else if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            idx <= nxt_idx;
            if (slot_en[nxt_idx]) dbg_addr <= slot_reg[nxt_idx];
          end
        end
        S_CMP: begin
          if (dbg_data != slot_exp[idx]) begin
            state      <= S_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            pass       <= 1'b0;
            fail_idx   <= idx;
            fail_value <= dbg_data;
          end else if (idx == LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= 1'b1;
          end else begin
            state <= S_ADDR;
            idx   <= nxt_idx;
            if (slot_en[nxt_idx]) dbg_addr <= slot_reg[nxt_idx];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
